// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues PC fetches to instruction memory with credit-based flow
// control, buffers in-order responses and drains stale responses after a flush.
// Define IFQ_BYPASS_EN to add a same-cycle response-to-decode bypass when the queue is empty.
module instr_fetch_queue #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC,
  input  logic             pc_valid,
  output logic             pc_ready,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             flush,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  typedef enum logic {RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   discard_q, discard_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic            err_q, err_d;

  logic [WIDTH-1:0] q_pc_mem   [DEPTH];
  logic [WIDTH-1:0] q_data_mem [DEPTH];
  logic [WIDTH-1:0] tag_mem    [MAX_OUT];

  logic            run, credit, issue, rsp_hit, rsp_err, push, pop;
  logic [SW-1:0]   occupancy;
  logic [OW-1:0]   drain_cnt;
  logic [WIDTH-1:0] head_pc, head_data, tag_pc;

  // Tag FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  assign run       = (state_q == RUN);
  assign occupancy = SW'(count_q) + SW'(out_q);
  assign credit    = run && (occupancy < SW'(DEPTH)) && (out_q < OW'(MAX_OUT));

  assign imem_req  = !rst && pc_valid && credit && !flush;
  assign imem_addr = PC;
  assign pc_ready  = imem_req && imem_gnt;
  assign issue     = pc_ready;

  assign rsp_hit   = !rst && imem_rvalid && run && (out_q != '0);
  assign rsp_err   = imem_rvalid && run && (out_q == '0);
  assign drain_cnt = out_q - OW'(rsp_hit);

  assign head_pc   = q_pc_mem[rd_ptr_q];
  assign head_data = q_data_mem[rd_ptr_q];
  assign tag_pc    = tag_mem[tag_rd_q];
  assign err       = err_q;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass      = rsp_hit && !flush && (count_q == '0);
  assign instr_valid = !rst && !flush && ((count_q != '0) || bypass);
  assign instr       = bypass ? imem_rdata : (instr_valid ? head_data : '0);
  assign instr_pc    = bypass ? tag_pc     : (instr_valid ? head_pc   : '0);
  assign pop         = instr_valid && instr_ready && (count_q != '0);
  assign push        = rsp_hit && !flush && !(bypass && instr_ready);
`else
  assign instr_valid = !rst && !flush && (count_q != '0);
  assign instr       = instr_valid ? head_data : '0;
  assign instr_pc    = instr_valid ? head_pc   : '0;
  assign pop         = instr_valid && instr_ready;
  assign push        = rsp_hit && !flush;
`endif

  // NOTE: every next-state variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    out_d     = out_q;
    discard_d = discard_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    tag_rd_d  = tag_rd_q;
    tag_wr_d  = tag_wr_q;
    err_d     = err_q || rsp_err;

    case (state_q)
      RUN: begin
        if (flush) begin
          count_d  = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          tag_rd_d = '0;
          tag_wr_d = '0;
          out_d    = '0;
          if (drain_cnt != '0) begin
            state_d   = DRAIN;
            discard_d = drain_cnt;
          end
        end else begin
          if (issue)   tag_wr_d = tag_inc(tag_wr_q);
          if (rsp_hit) tag_rd_d = tag_inc(tag_rd_q);
          case ({issue, rsp_hit})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
          endcase
          if (push) wr_ptr_d = wr_ptr_q + AW'(1);
          if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
          case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
          endcase
        end
      end
      DRAIN: begin
        if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - OW'(1);
        if (!flush && (discard_d == '0)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      count_q   <= '0;
      out_q     <= '0;
      discard_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      tag_rd_q  <= '0;
      tag_wr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      out_q     <= out_d;
      discard_q <= discard_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      tag_rd_q  <= tag_rd_d;
      tag_wr_q  <= tag_wr_d;
      err_q     <= err_d;
    end
  end

  // NOTE: storage arrays are not reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr_q] <= PC;
    if (push) begin
      q_pc_mem[wr_ptr_q]   <= tag_pc;
      q_data_mem[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed stimulus, a one-cycle-latency memory
// model and a scoreboard monitor comparing every instruction decode consumes.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        pc_valid, pc_ready, imem_req, imem_gnt, imem_rvalid, flush;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc;
  logic        instr_valid, instr_ready, err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  logic        mem_hold = 1'b0;
  logic        mem_spur = 1'b0;
  logic        prev_rv;
  int          total = 0;
  int          bad = 0;
  int          issued;
  logic [31:0] next_pc;

  instr_fetch_queue #(.WIDTH(32), .DEPTH(4), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst), .PC(PC), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: accepted addresses answer one cycle later, in order, unless held.
  always @(negedge clk) begin
    if (rst) pend_q.delete();
    else if (pc_ready) pend_q.push_back(imem_addr);
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (!mem_hold && pend_q.size() > 0) begin
      logic [31:0] a;
      a = pend_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = (a == 32'h20) ? 32'h0050_0093 : (a ^ 32'h1357_0013);
    end else if (mem_spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Scoreboard monitor: compares every instruction consumed by decode.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got pc %0h, none expected", instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_pc", instr_pc, e.pc);
        check("pop_instr", instr, e.data);
      end
    end
  end

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Drive one cycle just after the rising edge, then return at the falling edge for checks.
  task automatic cyc(input logic r, input logic pv, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    rst = r; pc_valid = pv; PC = pc; instr_ready = rdy; flush = fl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; pc_valid = 1'b1; PC = 32'h40; imem_gnt = 1'b1;
    flush = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_pc_ready", pc_ready, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_err", err, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);

    // Basic stream 0x0/0x4/0x8 with decode always ready.
    expect_instr(32'h0, 32'h1357_0013);
    expect_instr(32'h4, 32'h1357_0017);
    expect_instr(32'h8, 32'h1357_001B);
    prev_rv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'(i < 3), 32'(4 * i), 1'b1, 1'b0);
      if (i < 3) check("t1_pc_ready", pc_ready, 1);
`ifndef IFQ_BYPASS_EN
      check("t1_valid_latency", instr_valid, prev_rv);
`endif
      prev_rv = imem_rvalid;
    end
    idle(2);
    check("t1_drained", exp_q.size(), 0);
    check("t1_err", err, 0);

    // Decode stalled: exactly DEPTH fetches, no credit returned by the pop cycle itself.
    expect_instr(32'h200, 32'h1357_0213);
    expect_instr(32'h204, 32'h1357_0217);
    expect_instr(32'h208, 32'h1357_021B);
    expect_instr(32'h20C, 32'h1357_021F);
    expect_instr(32'h210, 32'h1357_0203);
    next_pc = 32'h200;
    issued = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, next_pc, 1'b0, 1'b0);
      if (pc_ready) begin
        issued++;
        next_pc += 32'h4;
      end
    end
    check("t2_issued", issued, 4);
    check("t2_full_valid", instr_valid, 1);
    cyc(1'b0, 1'b1, next_pc, 1'b1, 1'b0);
    check("t2_pop_no_credit", pc_ready, 0);
    cyc(1'b0, 1'b1, next_pc, 1'b0, 1'b0);
    check("t2_credit_after_pop", pc_ready, 1);
    idle(8);
    check("t2_drained", exp_q.size(), 0);

    // Flush with two outstanding and one queued entry.
    cyc(1'b0, 1'b1, 32'h2F0, 1'b0, 1'b0);
    check("t3_issue0", pc_ready, 1);
    cyc(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
    check("t3_issue1", pc_ready, 1);
    mem_hold = 1'b1;
    cyc(1'b0, 1'b1, 32'h304, 1'b0, 1'b0);
    check("t3_issue2", pc_ready, 1);
    check("t3_queued", instr_valid, 1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("t3_flush_valid", instr_valid, 0);
    check("t3_flush_req", imem_req, 0);
    expect_instr(32'h100, 32'h1357_0113);
    cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    check("t3_empty", instr_valid, 0);
    check("t3_drain_req", imem_req, 0);
    mem_hold = 1'b0;
    cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    check("t3_drain_rsp1", pc_ready, 0);
    cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    check("t3_drain_rsp2", pc_ready, 0);
    cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    check("t3_refetch", pc_ready, 1);
    idle(4);
    check("t3_drained", exp_q.size(), 0);
    check("t3_err", err, 0);

    // Spurious response with nothing outstanding.
    expect_instr(32'h400, 32'h1357_0413);
    cyc(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
    check("t4_issue", pc_ready, 1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t4_held", instr_valid, 1);
    mem_spur = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    mem_spur = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t4_err_set", err, 1);
    check("t4_head_pc", instr_pc, 32'h400);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("t4_no_extra_entry", instr_valid, 0);
    check("t4_err_sticky", err, 1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    check("t4_err_cleared", err, 0);
    check("t4_drained", exp_q.size(), 0);

    // Reset while a fetch is in flight; its response lands during reset.
    expect_instr(32'h600, 32'h1357_0613);
    cyc(1'b0, 1'b1, 32'h500, 1'b1, 1'b0);
    check("t5_issue", pc_ready, 1);
    cyc(1'b1, 1'b1, 32'h500, 1'b1, 1'b0);
    check("t5_rst_valid", instr_valid, 0);
    check("t5_rst_pc_ready", pc_ready, 0);
    check("t5_rst_req", imem_req, 0);
    check("t5_rst_instr", instr, 0);
    check("t5_rst_instr_pc", instr_pc, 0);
    cyc(1'b0, 1'b1, 32'h600, 1'b1, 1'b0);
    check("t5_refetch", pc_ready, 1);
    idle(4);
    check("t5_err", err, 0);
    check("t5_drained", exp_q.size(), 0);

`ifdef IFQ_BYPASS_EN
    // Same-cycle bypass from an empty queue.
    expect_instr(32'h20, 32'h0050_0093);
    cyc(1'b0, 1'b1, 32'h20, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_valid", instr_valid, 1);
    check("bp_pc", instr_pc, 32'h20);
    check("bp_instr", instr, 32'h0050_0093);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_count_zero", instr_valid, 0);
`endif

    idle(2);
    check("final_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
